// File: rtl/euler_step_scheduler.sv
// Step scheduler for an explicit-Euler datapath: issues steps, halves h on error, counts accepted steps.
// Optional watchdog on the WAIT state is enabled by defining EULER_WDOG_EN.
//
// state | meaning
// IDLE  | waiting for start; fault/step_count hold results of the last run
// ISSUE | launch one step in the datapath
// WAIT  | waiting for the datapath step_done strobe
// EVAL  | accept the step, or halve h and retry, or give up
// DONE  | emit final_done and drop busy
module euler_step_scheduler #(
  parameter int CNT_W     = 16,
  parameter int MAX_RETRY = 4,
  parameter int WDOG_CYC  = 1023
) (
  input  logic             clk,
  input  logic             rst_sync,
  input  logic             start,
  input  logic [CNT_W-1:0] n_steps,
  output logic             step_start,
  input  logic             step_done,
  input  logic             err_flag,
  output logic             halve_h,
  output logic             busy,
  output logic             final_done,
  output logic             fault,
  output logic [CNT_W-1:0] step_count
);

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             err_q, err_d;
  logic             step_start_q, step_start_d;
  logic             halve_q, halve_d;
  logic             busy_q, busy_d;
  logic             final_done_q, final_done_d;
  logic             fault_q, fault_d;

`ifdef EULER_WDOG_EN
  localparam int WD_W = (WDOG_CYC < 2) ? 1 : $clog2(WDOG_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    count_d      = count_q;
    retry_d      = retry_q;
    err_d        = err_q;
    busy_d       = busy_q;
    fault_d      = fault_q;
    step_start_d = 1'b0;
    halve_d      = 1'b0;
    final_done_d = 1'b0;
    cnt_inc      = count_q + CNT_W'(1);
`ifdef EULER_WDOG_EN
    wdog_d       = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          target_d = n_steps;
          count_d  = '0;
          retry_d  = '0;
          fault_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = (n_steps == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        step_start_d = 1'b1;
`ifdef EULER_WDOG_EN
        wdog_d       = '0;
`endif
        state_d      = WAIT;
      end
      WAIT: begin
        if (step_done) begin
          err_d   = err_flag;
          state_d = EVAL;
        end
`ifdef EULER_WDOG_EN
        else if (wdog_q == WD_LAST) begin
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
`endif
      end
      EVAL: begin
        if (err_q) begin
          if (retry_q < RTY_MAX) begin
            halve_d = 1'b1;
            retry_d = retry_q + RTY_W'(1);
            state_d = ISSUE;
          end else begin
            fault_d = 1'b1;
            state_d = DONE;
          end
        end else begin
          // target is nonzero here, so the count can never pass it and wrap
          count_d = cnt_inc;
          retry_d = '0;
          state_d = (cnt_inc == target_q) ? DONE : ISSUE;
        end
      end
      DONE: begin
        final_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst_sync) begin
      state_q      <= IDLE;
      target_q     <= '0;
      count_q      <= '0;
      retry_q      <= '0;
      err_q        <= 1'b0;
      step_start_q <= 1'b0;
      halve_q      <= 1'b0;
      busy_q       <= 1'b0;
      final_done_q <= 1'b0;
      fault_q      <= 1'b0;
`ifdef EULER_WDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      count_q      <= count_d;
      retry_q      <= retry_d;
      err_q        <= err_d;
      step_start_q <= step_start_d;
      halve_q      <= halve_d;
      busy_q       <= busy_d;
      final_done_q <= final_done_d;
      fault_q      <= fault_d;
`ifdef EULER_WDOG_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign step_start = step_start_q;
  assign halve_h    = halve_q;
  assign busy       = busy_q;
  assign final_done = final_done_q;
  assign fault      = fault_q;
  assign step_count = count_q;

endmodule
